// File: rtl/cpu_fetch_stage_if.sv
// Instruction bus between the fetch stage (master) and memory (slave).
// One read at a time: request/address held until a single-cycle ready strobe.
`timescale 1ns/1ps
interface cpu_fetch_stage_if;
  logic        bus_request;
  logic [31:0] bus_address;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  modport master (
    output bus_request,
    output bus_address,
    input  bus_ready,
    input  bus_rdata
  );

  modport slave (
    input  bus_request,
    input  bus_address,
    output bus_ready,
    output bus_rdata
  );
endinterface

// File: rtl/cpu_fetch_stage.sv
// Instruction fetch stage: one outstanding bus read, publishes word/PC/tag to
// decode, honours downstream stall and redirects without cancelling a read.
`timescale 1ns/1ps
module cpu_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_busy,
  input  logic               i_jump,
  input  logic        [31:0] i_jump_pc,
  cpu_fetch_stage_if.master  bus,
  output logic         [7:0] o_tag,
  output logic        [31:0] o_instruction,
  output logic        [31:0] o_pc
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  localparam logic [31:0] RESET_PC_W = RESET_PC & ~32'h3;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] held_q, held_d;
  logic        discard_q, discard_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic  [7:0] tag_q, tag_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;

  logic [31:0] jump_pc;
  logic        publish;
  logic [31:0] pub_word;

  assign jump_pc = i_jump_pc & ~32'h3;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC_W;
      held_q       <= 32'h0;
      discard_q    <= 1'b0;
      pending_pc_q <= 32'h0;
      req_q        <= 1'b0;
      addr_q       <= 32'h0;
      tag_q        <= 8'h0;
      instr_q      <= 32'h0;
      opc_q        <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      held_q       <= held_d;
      discard_q    <= discard_d;
      pending_pc_q <= pending_pc_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      tag_q        <= tag_d;
      instr_q      <= instr_d;
      opc_q        <= opc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    held_d       = held_q;
    discard_d    = discard_q;
    pending_pc_d = pending_pc_q;
    req_d        = req_q;
    addr_d       = addr_q;
    tag_d        = tag_q;
    instr_d      = instr_q;
    opc_d        = opc_q;
    publish      = 1'b0;
    pub_word     = held_q;

    case (state_q)
      IDLE: begin
        if (i_jump) begin
          pc_d = jump_pc;
        end else begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus.bus_ready) begin
          // Redirect is deferred until the read completes; last jump wins.
          if (i_jump) begin
            discard_d    = 1'b1;
            pending_pc_d = jump_pc;
          end
        end else begin
          req_d     = 1'b0;
          discard_d = 1'b0;
          state_d   = IDLE;
          if (i_jump) begin
            pc_d = jump_pc;
          end else if (discard_q) begin
            pc_d = pending_pc_q;
          end else if (!i_busy) begin
            publish  = 1'b1;
            pub_word = bus.bus_rdata;
          end else begin
            held_d  = bus.bus_rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (i_jump) begin
          pc_d    = jump_pc;
          state_d = IDLE;
        end else if (!i_busy) begin
          publish  = 1'b1;
          pub_word = held_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Decode sees a new word only through a tag change.
    if (publish) begin
      instr_d = pub_word;
      opc_d   = pc_q;
      tag_d   = tag_q + 8'd1;
      pc_d    = pc_q + 32'd4;
    end
  end

  assign bus.bus_request = req_q;
  assign bus.bus_address = addr_q;
  assign o_tag           = tag_q;
  assign o_instruction   = instr_q;
  assign o_pc            = opc_q;

endmodule

// File: doc/cpu_fetch_stage.md
# cpu_fetch_stage

Instruction fetch stage of the CPU pipeline. Reads 32-bit instruction words over a simple request/ready bus. It publishes each word together with its PC and a sequence tag to the decode path, where the skid buffer sits directly downstream. It honours downstream backpressure (`i_busy`) and redirects on jumps without ever aborting a bus transaction.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; bits [1:0] are treated as zero.
- `i_clock` in 1: single clock; all state updates on the rising edge.
- `i_reset` in 1: asynchronous, active-low reset.
- `i_busy` in 1: downstream stall; when high, no new word is published.
- `i_jump` in 1: redirect request, sampled each cycle.
- `i_jump_pc` in 32: redirect target; bits [1:0] forced to 0 internally.
- `o_bus_request` out 1: read request, held high until `i_bus_ready`.
- `o_bus_address` out 32: word address; stable while `o_bus_request` is high.
- `i_bus_ready` in 1: single-cycle completion strobe; ignored while `o_bus_request` is low.
- `i_bus_rdata` in 32: read data, valid in the cycle `i_bus_ready` is high.
- `o_tag` out 8: sequence tag; increments by 1 (mod 256) on each publish.
- `o_instruction` out 32: published instruction word.
- `o_pc` out 32: PC of `o_instruction`.

## Operation
- Registers:
  - `pc` (32).
  - `state` ∈ {IDLE, WAIT, HOLD}.
  - `held` (32): captured word.
  - `discard` (1).
  - `pending_pc` (32).
- Publish means: `o_instruction`←word, `o_pc`←pc, `o_tag`←`o_tag`+1, `pc`←pc+4 (32-bit wrap). Outputs otherwise hold their values.
- IDLE:
  - If `i_jump`: `pc`←`i_jump_pc`, stay IDLE.
  - Else: `o_bus_request`←1, `o_bus_address`←pc, go to WAIT.
- WAIT, no `i_bus_ready`:
  - If `i_jump`: `discard`←1, `pending_pc`←`i_jump_pc`.
  - A later jump overwrites `pending_pc` (last wins).
- WAIT, `i_bus_ready`: `o_bus_request`←0, then the first matching case applies.
  - `i_jump` high: drop the word, `pc`←`i_jump_pc`, clear `discard`, go to IDLE. The same-cycle jump wins over `pending_pc`.
  - `discard` set: drop the word, `pc`←`pending_pc`, clear `discard`, go to IDLE.
  - `!i_busy`: publish `i_bus_rdata`, go to IDLE.
  - Otherwise: `held`←`i_bus_rdata`, go to HOLD.
- HOLD (`o_bus_request` = 0):
  - If `i_jump`: drop `held`, `pc`←`i_jump_pc`, go to IDLE.
  - Else if `!i_busy`: publish `held`, go to IDLE.
  - Else: stay in HOLD.
- Jump-dropped words are never published; `o_tag` is unchanged for them.
- Published outputs change only at an edge where `i_busy` was low. The downstream stage detects a new word by a change of `o_tag`.
- At most one bus transaction is outstanding; a transaction is never cancelled.

## Timing
- Reset, asynchronous on `i_reset`=0:
  - Outputs cleared immediately: `o_bus_request`=0, `o_bus_address`=0, `o_tag`=0, `o_instruction`=0, `o_pc`=0.
  - Internal: `pc`=`RESET_PC`, `state`=IDLE, `discard`=0, `held`=0.
  - Reset asserted mid-transaction drops the request at once; any later `i_bus_ready` is ignored.
- First request rises at the first clock edge after reset is released.
- Request to publish:
  - With `i_bus_ready` in the first cycle after request rise, the word is published at that same edge.
  - Peak throughput: 1 word per 2 cycles (one IDLE cycle between transactions).
- `o_bus_address` never changes while `o_bus_request` = 1.
- HOLD → publish happens at the first edge with `i_busy`=0. The next request rises one cycle later.
- Tag wraps 255→0. PC wraps 32'hFFFF_FFFC→0.

## Test plan
- Reset with `RESET_PC`=0x100; bus always ready next cycle; `i_busy`=0 for 8 words:
  - Addresses 0x100, 0x104, …, 0x11C, each one cycle of request.
  - `o_pc` matches each address; `o_tag` runs 1..8; one request every 2 cycles.
- `i_busy`=1 for 5 cycles while a word returns:
  - Word held in HOLD, no new request, outputs unchanged.
  - Published at the first edge with `i_busy`=0; next request at pc+4.
- `i_jump` to 0x203 while WAIT with ready delayed 3 cycles:
  - Address stays stable; returned word not published; tag unchanged.
  - Next request address is 0x200.
- Two jumps (0x400, then 0x500) during one outstanding request, plus a jump to 0x600 coincident with `i_bus_ready`:
  - Next fetch address is 0x600; no publish.
- Jump to 0x800 in HOLD:
  - Held word dropped; next request at 0x800; tag unchanged.
- 256 publishes, then `i_reset` low mid-request:
  - Tag wraps 255→0.
  - Request, tag and outputs go to 0 without waiting for a clock edge.
  - Restart fetches from `RESET_PC`.
